// File: rtl/act_ctrl.sv
// Activation broadcast controller: walks the non-zero entries of the input activation
// file, broadcasts each one with a valid/ready handshake, then swaps and clears the ping-pong pair.
module act_ctrl #(
    parameter int PE_ACT_NO  = 16,
    parameter int ACT_ADDR_W = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  layer_start,
    input  logic                  compute_done,
    input  logic [PE_ACT_NO-1:0]  in_act_zeros,
    input  logic [DATA_WIDTH-1:0] in_act_read_data,
    input  logic                  act_ready,
    output logic                  dir,
    output logic                  in_act_read_en,
    output logic [ACT_ADDR_W-1:0] in_act_read_addr,
    output logic                  out_act_clear,
    output logic                  act_valid,
    output logic [ACT_ADDR_W-1:0] act_addr,
    output logic [DATA_WIDTH-1:0] act_data,
    output logic                  busy,
    output logic                  layer_done,
    output logic [ACT_ADDR_W:0]   act_count
);

    typedef enum logic [2:0] {IDLE, SCAN, READ, SEND, DRAIN, SWAP, CLEAR} state_t;

    localparam logic [ACT_ADDR_W:0] CNT_ONE = {{ACT_ADDR_W{1'b0}}, 1'b1};

    state_t                  state_q;
    logic [PE_ACT_NO-1:0]    pending_q;
    logic [ACT_ADDR_W-1:0]   sel_q;
    logic [ACT_ADDR_W-1:0]   sel_d;
    logic [ACT_ADDR_W-1:0]   act_addr_q;
    logic [DATA_WIDTH-1:0]   act_data_q;
    logic [ACT_ADDR_W:0]     act_count_q;
    logic                    dir_q;

    // Priority encoder: lowest set bit wins, so scan from the top down.
    function automatic logic [ACT_ADDR_W-1:0] lowest_set(input logic [PE_ACT_NO-1:0] v);
        logic [ACT_ADDR_W-1:0] idx;
        idx = '0;
        for (int k = PE_ACT_NO - 1; k >= 0; k--) begin
            if (v[k]) idx = k[ACT_ADDR_W-1:0];
        end
        return idx;
    endfunction

    assign sel_d = lowest_set(pending_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            sel_q       <= '0;
            act_addr_q  <= '0;
            act_data_q  <= '0;
            act_count_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (layer_start) begin
                        pending_q   <= ~in_act_zeros;
                        act_count_q <= '0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (pending_q == '0) begin
                        state_q <= DRAIN;
                    end else begin
                        sel_q   <= sel_d;
                        state_q <= READ;
                    end
                end
                READ: begin
                    act_data_q <= in_act_read_data;
                    act_addr_q <= sel_q;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (act_ready) begin
                        pending_q[sel_q] <= 1'b0;
                        act_count_q      <= act_count_q + CNT_ONE;
                        state_q          <= SCAN;
                    end
                end
                DRAIN: begin
                    if (compute_done) state_q <= SWAP;
                end
                SWAP: begin
                    dir_q   <= ~dir_q;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode directly from the state register so each lasts exactly one state.
    assign dir              = dir_q;
    assign in_act_read_en   = (state_q == SCAN) && (pending_q != '0);
    assign in_act_read_addr = sel_d;
    assign out_act_clear    = (state_q == CLEAR);
    assign layer_done       = (state_q == CLEAR);
    assign act_valid        = (state_q == SEND);
    assign act_addr         = act_addr_q;
    assign act_data         = act_data_q;
    assign busy             = (state_q != IDLE);
    assign act_count        = act_count_q;

endmodule

// File: tb/tb_act_ctrl.sv
// Directed bench for act_ctrl: broadcast order, back-pressure, empty layer,
// ping-pong direction and mid-layer reset.
module tb_act_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        layer_start;
    logic        compute_done;
    logic [15:0] in_act_zeros;
    logic [15:0] in_act_read_data;
    logic        act_ready;
    logic        dir;
    logic        in_act_read_en;
    logic [3:0]  in_act_read_addr;
    logic        out_act_clear;
    logic        act_valid;
    logic [3:0]  act_addr;
    logic [15:0] act_data;
    logic        busy;
    logic        layer_done;
    logic [4:0]  act_count;

    int vectors = 0;
    int miscompares = 0;

    act_ctrl #(.PE_ACT_NO(16), .ACT_ADDR_W(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .compute_done(compute_done),
        .in_act_zeros(in_act_zeros), .in_act_read_data(in_act_read_data), .act_ready(act_ready),
        .dir(dir), .in_act_read_en(in_act_read_en), .in_act_read_addr(in_act_read_addr),
        .out_act_clear(out_act_clear), .act_valid(act_valid), .act_addr(act_addr),
        .act_data(act_data), .busy(busy), .layer_done(layer_done), .act_count(act_count)
    );

    always #5 clk = ~clk;

    // Activation file: entry i holds 16'h5A00 + i, one cycle read latency.
    always @(posedge clk) begin
        if (in_act_read_en) in_act_read_data <= 16'h5A00 + {12'h000, in_act_read_addr};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; layer_start = 1'b0; compute_done = 1'b0;
        in_act_zeros = 16'hFFFF; act_ready = 1'b1; in_act_read_data = 16'h0000;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_dir", dir, 0);
        chk("rst_valid", act_valid, 0);
        chk("rst_count", act_count, 0);
        chk("rst_addr", act_addr, 0);
        chk("rst_data", act_data, 0);
        chk("rst_rden", in_act_read_en, 0);
        chk("rst_clear", out_act_clear, 0);
        chk("rst_done", layer_done, 0);
        rst_n = 1'b1;
        step();

        // Layer 1: entries 1 and 3 non-zero, downstream always ready.
        in_act_zeros = 16'hFFF5; layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        in_act_zeros = 16'h0000;
        chk("l1_scan_rden", in_act_read_en, 1);
        chk("l1_scan_addr", in_act_read_addr, 1);
        chk("l1_busy", busy, 1);
        step();
        chk("l1_read_rden", in_act_read_en, 0);
        chk("l1_read_valid", act_valid, 0);
        step();
        chk("l1_send0_valid", act_valid, 1);
        chk("l1_send0_addr", act_addr, 1);
        chk("l1_send0_data", act_data, 16'h5A01);
        chk("l1_send0_count", act_count, 0);
        step();
        chk("l1_scan1_count", act_count, 1);
        chk("l1_scan1_valid", act_valid, 0);
        chk("l1_scan1_rden", in_act_read_en, 1);
        chk("l1_scan1_addr", in_act_read_addr, 3);
        step(); step();
        chk("l1_send1_valid", act_valid, 1);
        chk("l1_send1_addr", act_addr, 3);
        chk("l1_send1_data", act_data, 16'h5A03);
        step();
        chk("l1_scan2_count", act_count, 2);
        chk("l1_scan2_rden", in_act_read_en, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("l1_drain_busy", busy, 1);
            chk("l1_drain_dir", dir, 0);
            chk("l1_drain_done", layer_done, 0);
            step();
        end
        compute_done = 1'b1;
        step();
        chk("l1_swap_dir", dir, 0);
        chk("l1_swap_done", layer_done, 0);
        step();
        chk("l1_clear_dir", dir, 1);
        chk("l1_clear_done", layer_done, 1);
        chk("l1_clear_clr", out_act_clear, 1);
        step();
        chk("l1_idle_busy", busy, 0);
        chk("l1_idle_done", layer_done, 0);
        chk("l1_idle_clr", out_act_clear, 0);
        chk("l1_idle_count", act_count, 2);
        compute_done = 1'b0;
        step(); step();
        chk("l1_hold_count", act_count, 2);

        // Layer 2: only entry 0, back-pressure for 5 cycles, stray layer_start.
        in_act_zeros = 16'hFFFE; act_ready = 1'b0; layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        chk("l2_scan_addr", in_act_read_addr, 0);
        step(); step();
        layer_start = 1'b1;
        in_act_zeros = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            chk("l2_stall_valid", act_valid, 1);
            chk("l2_stall_addr", act_addr, 0);
            chk("l2_stall_data", act_data, 16'h5A00);
            chk("l2_stall_count", act_count, 0);
            step();
            layer_start = 1'b0;
        end
        act_ready = 1'b1; compute_done = 1'b1;
        step();
        chk("l2_rel_count", act_count, 1);
        chk("l2_rel_rden", in_act_read_en, 0);
        step();
        chk("l2_drain_valid", act_valid, 0);
        step();
        chk("l2_swap_dir", dir, 1);
        step();
        chk("l2_clear_dir", dir, 0);
        chk("l2_clear_done", layer_done, 1);
        step();
        chk("l2_idle_count", act_count, 1);
        chk("l2_idle_busy", busy, 0);

        // Layer 3: all-zero layer with compute already done.
        in_act_zeros = 16'hFFFF; layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        chk("l3_scan_rden", in_act_read_en, 0);
        step();
        chk("l3_drain_rden", in_act_read_en, 0);
        chk("l3_drain_busy", busy, 1);
        step();
        chk("l3_swap_done", layer_done, 0);
        chk("l3_swap_dir", dir, 0);
        step();
        chk("l3_clear_dir", dir, 1);
        chk("l3_clear_done", layer_done, 1);
        chk("l3_clear_clr", out_act_clear, 1);
        chk("l3_clear_count", act_count, 0);
        step();
        chk("l3_idle_done", layer_done, 0);

        // Layer 4: reset while sending with dir=1.
        compute_done = 1'b0; act_ready = 1'b0;
        in_act_zeros = 16'hFFFB; layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        step(); step();
        chk("l4_send_valid", act_valid, 1);
        chk("l4_send_addr", act_addr, 2);
        chk("l4_send_data", act_data, 16'h5A02);
        rst_n = 1'b0;
        step();
        chk("l4_rst_busy", busy, 0);
        chk("l4_rst_valid", act_valid, 0);
        chk("l4_rst_dir", dir, 0);
        chk("l4_rst_done", layer_done, 0);
        chk("l4_rst_clr", out_act_clear, 0);
        chk("l4_rst_count", act_count, 0);
        rst_n = 1'b1;
        step();
        chk("l4_post_done", layer_done, 0);
        chk("l4_post_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/act_ctrl.md
ACT_CTRL -- requirements
Module: act_ctrl

Interface
REQ-001 Parameter PE_ACT_NO, default 16: activation register file depth per PE.
REQ-002 Parameter ACT_ADDR_W, default 4: address width; SHALL equal ceil(log2(PE_ACT_NO)).
REQ-003 Parameter DATA_WIDTH, default 16: activation data width.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 layer_start  in  1  one-cycle pulse; begin broadcasting the current input activations.
REQ-007 compute_done  in  1  level; downstream MAC array has drained all work for the layer.
REQ-008 in_act_zeros  in  PE_ACT_NO  per-entry zero flags of the current input activation file.
REQ-009 in_act_read_data  in  DATA_WIDTH  input activation file read data, valid the cycle after in_act_read_en.
REQ-010 act_ready  in  1  downstream accepts the broadcast activation.
REQ-011 dir  out  1  ping-pong direction select for the activation file pair.
REQ-012 in_act_read_en  out  1  input activation file read enable.
REQ-013 in_act_read_addr  out  ACT_ADDR_W  input activation file read address.
REQ-014 out_act_clear  out  1  output activation file clear.
REQ-015 act_valid  out  1  broadcast activation valid.
REQ-016 act_addr  out  ACT_ADDR_W  index of the broadcast activation.
REQ-017 act_data  out  DATA_WIDTH  value of the broadcast activation.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 layer_done  out  1  one-cycle pulse at layer completion.
REQ-020 act_count  out  ACT_ADDR_W+1  number of activations broadcast in the current/last layer.

Function
REQ-021 States: IDLE, SCAN, READ, SEND, DRAIN, SWAP, CLEAR.
REQ-022 IDLE: on layer_start, capture pending <= ~in_act_zeros, act_count <= 0, go SCAN; otherwise hold.
REQ-023 layer_start outside IDLE SHALL be ignored, with no state or counter effect.
REQ-024 SCAN: if pending == 0 go DRAIN; else select lowest set index i, drive in_act_read_en=1 and in_act_read_addr=i for exactly this cycle, register i, go READ.
REQ-025 READ: register in_act_read_data into act_data and i into act_addr, go SEND.
REQ-026 SEND: act_valid=1; act_addr/act_data stable until handshake; on act_valid&&act_ready clear pending[i], act_count += 1, go SCAN.
REQ-027 Minimum spacing SHALL be 3 cycles per broadcast activation (SCAN, READ, SEND with act_ready high).
REQ-028 act_valid SHALL NOT deassert in SEND without a handshake.
REQ-029 DRAIN: wait for compute_done=1 and go SWAP; compute_done already high on entry SHALL give a 1-cycle DRAIN.
REQ-030 SWAP: dir <= ~dir; go CLEAR.
REQ-031 CLEAR: out_act_clear=1 for exactly this cycle, with dir already toggled so the clear hits the former input file; layer_done=1; go IDLE.
REQ-032 Zero layer, all in_act_zeros bits 1: SCAN->DRAIN with no read and act_count=0; SWAP and CLEAR still occur.
REQ-033 in_act_zeros changes after capture SHALL NOT affect the current layer.
REQ-034 act_count SHALL hold its final value in IDLE until the next accepted layer_start.
REQ-035 in_act_read_en, out_act_clear, act_valid and layer_done SHALL be 0 in every state not named above for them.

Reset
REQ-036 On rst_n=0 at a clk edge: state=IDLE, dir=0, pending=0, act_count=0, act_addr=0, act_data=0, and all single-bit outputs 0.
REQ-037 Reset mid-layer SHALL abort immediately with no layer_done and no out_act_clear, and return dir to 0.

Verification
REQ-038 PE_ACT_NO=16, in_act_zeros=16'hFFF5, act_ready=1 -> broadcasts addr 1 then 3 with the captured data, 3 cycles apart; act_count=2; then DRAIN.
REQ-039 In SEND, hold act_ready=0 for 5 cycles -> act_valid, act_addr and act_data stable for all 5 cycles; one increment of act_count after release.
REQ-040 in_act_zeros=16'hFFFF with compute_done=1 -> no in_act_read_en; SWAP then CLEAR; dir 0->1; layer_done and out_act_clear high in the same single cycle; act_count=0.
REQ-041 Two back-to-back layers -> dir sequence 0->1->0; layer_start pulsed during busy ignored, with no extra broadcast.
REQ-042 In DRAIN, hold compute_done=0 for 10 cycles -> remains in DRAIN, dir unchanged; compute_done=1 -> SWAP on the next edge.
REQ-043 rst_n=0 during SEND after dir=1 -> next cycle IDLE, act_valid=0, dir=0, no layer_done.
